ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It consumes the operands and function select carried out of the ID/EX pipeline register and returns a 32-bit result. While it is working it asserts `busy`, which holds the front of the pipeline. It is a radix-2, one-bit-per-cycle engine with fast paths for the divide special cases.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: EX holds a valid M-extension instruction (opcode 0110011, funct7 0000001). Sampled only in IDLE.
- `funct3` in 3: operation select, equal to instruction[14:12]:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a` in 32: rs1 value after forwarding.
- `op_b` in 32: rs2 value after forwarding.
- `stall` in 1: memory busywait. Holds the unit in DONE.
- `flush` in 1: synchronous abort caused by a taken branch or jump.
- `busy` out 1: stall request to the IF/ID and ID/EX registers.
- `done` out 1: `result` is valid this cycle.
- `result` out 32: operation result. Registered and held until the next accepted start.

## Operation
- States:
  - IDLE: waiting for `start`.
  - CALC: iterating.
  - DONE: result presented.
- IDLE → CALC when `start` is high and `flush` is low. On that edge:
  - latch `funct3`;
  - latch |op_a| and |op_b|, taking the absolute value only when that operand is signed for the selected op;
  - latch the result-negate flag;
  - clear the 5-bit counter.
- Signedness per operand:
  - MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - DIV and REM: both signed.
  - MUL: sign handling does not affect the low 32 bits.
- IDLE → DONE directly, with no CALC, for the divide special cases:
  - divide by zero (op_b == 0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - signed overflow (op_a == 0x80000000, op_b == 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Multiply: shift-add over a 64-bit accumulator for 32 iterations.
  - Negate the 64-bit product if the negate flag is set.
  - MUL returns bits [31:0]; the other multiplies return bits [63:32].
- Divide: restoring division over a 33-bit partial remainder for 32 iterations.
  - Quotient is negated when the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- CALC → DONE after the counter reaches 31, i.e. after 32 CALC cycles. `result` is written on that edge.
- DONE → IDLE when `stall` is low. DONE holds while `stall` is high.
- `flush` in any state: go to IDLE on the next edge. `result` is not updated and `done` does not assert for the aborted op.
- `reset`: state IDLE, counter 0, internal registers 0, `result` 0.

## Timing
- Outputs:
  - `busy` = (IDLE & start & !flush) | CALC. It is combinational from `start` so the stall takes effect in the issue cycle.
  - `done` = DONE, registered. `busy` is low in DONE, so the ID/EX register advances and the writeback path captures `result` on the edge that leaves DONE.
- Reset values: `busy` 0, `done` 0, `result` 0x00000000.
- Latency, with start accepted at edge 0:
  - normal ops: DONE in cycle 33, 34 cycles of occupancy;
  - special-case divides: DONE in cycle 1.
- `start` is ignored in CALC and DONE. The same instruction stays in EX during those states, so no re-issue is possible.
- Throughput: a back-to-back M instruction can be accepted in the cycle after leaving DONE.
- Simultaneous `flush` and `start` in IDLE: flush wins. `busy` stays low and nothing starts.
- `reset` asserted mid-CALC: all outputs reach their reset values asynchronously. The op is lost.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD → `busy` high cycles 0–32, `done` in cycle 33, `result`=0xFFFFFFEB. MULHU of the same operands → 0x00000006.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIV -100/7 → 0xFFFFFFF2 (-14). REM -100/7 → 0xFFFFFFFE (-2). Each has `done` at cycle 33.
- Special cases, each with `done` in cycle 1 and no CALC:
  - DIV 5/0 → 0xFFFFFFFF;
  - REM 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000;
  - REM of the same operands → 0.
- `flush` at cycle 10 of a DIV → IDLE next cycle, `busy` low, `done` never asserts, `result` keeps its previous value. The next MUL then completes normally.
- `stall` high for 3 cycles on DONE entry → `done` and `result` held for 4 cycles, then IDLE. Separately, `reset` pulsed at cycle 20 of a MUL → `busy`=0, `done`=0, `result`=0 immediately.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with divide special-case fast paths.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            stall,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic            r_neg;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_last;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_final;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_last   = (r_cnt == 5'd31);

  // Operand sign handling: DIV/REM/MULH sign both operands, MULHSU only op_a.
  always_comb begin
    w_a_neg = 1'b0;
    w_b_neg = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin
        w_a_neg = op_a[XLEN-1];
        w_b_neg = op_b[XLEN-1];
      end
      3'b010: begin
        w_a_neg = op_a[XLEN-1];
        w_b_neg = 1'b0;
      end
      default: begin
        w_a_neg = 1'b0;
        w_b_neg = 1'b0;
      end
    endcase
  end

  // A remainder follows the dividend sign; every other result follows the sign product.
  assign w_neg   = (funct3 == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_a_abs = w_a_neg ? (ZERO - op_a) : op_a;
  assign w_b_abs = w_b_neg ? (ZERO - op_b) : op_b;

  assign w_div_zero = funct3[2] && (op_b == ZERO);
  assign w_div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES);
  assign w_special  = w_div_zero || w_div_ovf;

  // Special-case divide results; funct3[1] distinguishes REM from DIV.
  always_comb begin
    w_special_res = ZERO;
    if (w_div_zero) begin
      w_special_res = funct3[1] ? op_a : ALL_ONES;
    end else begin
      w_special_res = funct3[1] ? ZERO : MIN_NEG;
    end
  end

  // One iteration: multiply shifts {hi,lo} right after a conditional add, divide shifts left and trial-subtracts.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {1'b0, ZERO});
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_b};
    w_fits  = !w_diff[XLEN];
    if (r_funct3[2]) begin
      w_hi_nxt = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_fits};
    end else begin
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign w_prod = r_neg ? ({(2*XLEN){1'b0}} - {w_hi_nxt, w_lo_nxt}) : {w_hi_nxt, w_lo_nxt};

  // Final result selection from the last iteration's values.
  always_comb begin
    w_final = ZERO;
    case (r_funct3)
      3'b000:                 w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = r_neg ? (ZERO - w_lo_nxt) : w_lo_nxt;
      3'b110, 3'b111:         w_final = r_neg ? (ZERO - w_hi_nxt) : w_hi_nxt;
      default:                w_final = ZERO;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush aborts from any state and beats start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE: begin
        if (flush || !stall) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: busy is combinational on start so the stall lands in the issue cycle.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_IDLE:  busy = start && !flush;
      S_CALC:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture on accept, iteration in CALC, result write on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_funct3 <= 3'b000;
      r_hi     <= ZERO;
      r_lo     <= ZERO;
      r_b      <= ZERO;
      r_neg    <= 1'b0;
      r_cnt    <= 5'd0;
      r_result <= ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3 <= funct3;
            r_hi     <= ZERO;
            r_lo     <= w_a_abs;
            r_b      <= w_b_abs;
            r_neg    <= w_neg;
            r_cnt    <= 5'd0;
            if (w_special) begin
              r_result <= w_special_res;
            end
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
              r_result <= w_final;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_chk;
  int n_fail;
  logic [31:0] last_exp;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .stall  (stall),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RV32M reference results from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Issue one op, measure latency and busy cycles, check result and stall hold.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int sc);
    int cyc;
    int nb;
    logic [31:0] exp;
    exp = model(f, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; stall = (sc > 0);
    #1;
    chk("busy_issue", busy, 1);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    nb = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("latency", cyc, is_special(f, a, b) ? 1 : 33);
    chk("busy_cycles", nb, is_special(f, a, b) ? 0 : 32);
    chk("result", result, exp);
    for (int k = 2; k <= sc + 1; k++) begin
      @(negedge clk);
      chk("done_hold", done, 1);
      chk("result_hold", result, exp);
      if (k == sc + 1) stall = 1'b0;
    end
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    last_exp = exp;
  endtask

  initial begin
    int ndone;
    logic [2:0] f;
    logic [31:0] a;
    logic [31:0] b;
    int sel;
    n_chk = 0; n_fail = 0; last_exp = 32'd0;
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    stall = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);

    // Directed cases.
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 0);
    do_op(3'd3, 32'd7, 32'hFFFFFFFD, 0);
    do_op(3'd1, 32'h80000000, 32'h80000000, 0);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(3'd5, 32'd100, 32'd7, 0);
    do_op(3'd7, 32'd100, 32'd7, 0);
    do_op(3'd4, 32'hFFFFFF9C, 32'd7, 0);
    do_op(3'd6, 32'hFFFFFF9C, 32'd7, 0);
    do_op(3'd4, 32'd5, 32'd0, 0);
    do_op(3'd6, 32'd5, 32'd0, 0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 3);

    // Flush at cycle 10 of a DIV.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("flush_no_done", ndone, 0);
    chk("flush_result", result, last_exp);
    do_op(3'd0, 32'd12345, 32'd678, 0);

    // Simultaneous start and flush in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
    #1;
    chk("sf_busy", busy, 0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("sf_no_start", ndone, 0);
    chk("sf_result", result, last_exp);

    // Reset pulsed at cycle 20 of a MUL.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    #2 reset = 1'b0;
    last_exp = 32'd0;
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 0);

    // Randomized ops with biased operands.
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 15));
        4: b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      do_op(f, a, b, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
